// File: rtl/snake_control.sv
// rtl/snake_control.sv - control FSM sequencing init, move, shift, redraw and food for the snake datapath
module snake_control #(
    parameter int INIT_LEN    = 4,
    parameter int MAX_LEN     = 2047,
    parameter int MOVE_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  key,
    input  logic        isDead,
    input  logic        inc_length,
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        draw_q,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic        draw_curr,
    output logic        food_en,
    output logic        lock,
    output logic        check_inc,
    output logic [3:0]  cnt_status,
    output logic [2:0]  dir,
    output logic [10:0] length,
    output logic        dead
);
    localparam int TW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam logic [10:0] INIT_L = 11'(INIT_LEN);
    localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [2:0] DIR_UP = 3'b100, DIR_DOWN = 3'b110, DIR_LEFT = 3'b000, DIR_RIGHT = 3'b001;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_INIT, S_DRST, S_DWAIT, S_DRAW, S_FOOD, S_WAIT,
        S_UPD, S_CHK, S_HLD, S_SWAIT, S_SLD, S_SWR, S_DEAD
    } state_t;

    state_t         state_q, state_d;
    logic [10:0]    seg_q, seg_d;
    logic [3:0]     sub_q, sub_d;
    logic [10:0]    length_q, length_d;
    logic [2:0]     dir_q, dir_d;
    logic [2:0]     pend_q, pend_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           tick_pend_q, tick_pend_d;

    logic           tick_wrap;
    logic           last_seg;
    logic           key_vld;
    logic [2:0]     key_dir;
    logic [2:0]     dir_opp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            seg_q       <= '0;
            sub_q       <= '0;
            length_q    <= INIT_L;
            dir_q       <= DIR_UP;
            pend_q      <= DIR_UP;
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            sub_q       <= sub_d;
            length_q    <= length_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    // Key decode; a request reversing the current heading is dropped.
    always_comb begin
        key_vld = $onehot(key);
        key_dir = DIR_UP;
        case (key)
            4'b0010: key_dir = DIR_DOWN;
            4'b0100: key_dir = DIR_LEFT;
            4'b1000: key_dir = DIR_RIGHT;
            default: key_dir = DIR_UP;
        endcase
        case (dir_q)
            DIR_UP:    dir_opp = DIR_DOWN;
            DIR_DOWN:  dir_opp = DIR_UP;
            DIR_LEFT:  dir_opp = DIR_RIGHT;
            DIR_RIGHT: dir_opp = DIR_LEFT;
            default:   dir_opp = 3'b111;
        endcase
    end

    assign tick_wrap = (tick_cnt_q == TICK_LAST);
    assign last_seg  = (seg_q == length_q - 11'd1);

    always_comb begin
        state_d           = state_q;
        length_d          = length_q;
        dir_d             = dir_q;
        pend_d            = (key_vld && key_dir != dir_opp) ? key_dir : pend_q;
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        draw_q            = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        food_en           = 1'b0;
        lock              = 1'b0;
        check_inc         = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR: begin
                rst_address = 1'b1;
                length_d    = INIT_L;
                dir_d       = DIR_UP;
                pend_d      = DIR_UP;
                state_d     = S_INIT;
            end
            S_INIT: begin
                ld_q_def    = 1'b1;
                inc_address = 1'b1;
                ld_head     = (seg_q == 11'd0);
                if (seg_q == INIT_L - 11'd1) state_d = S_DRST;
            end
            S_DRST: begin
                rst_address = 1'b1;
                state_d     = S_DWAIT;
            end
            S_DWAIT: state_d = S_DRAW;
            S_DRAW: begin
                draw_q = 1'b1;
                if (sub_q == 4'hf) begin
                    inc_address = 1'b1;
                    state_d     = last_seg ? S_FOOD : S_DWAIT;
                end
            end
            S_FOOD: begin
                food_en = 1'b1;
                if (sub_q == 4'hf) state_d = isDead ? S_DEAD : S_WAIT;
            end
            S_WAIT:  if (tick_pend_q) state_d = S_UPD;
            S_UPD: begin
                update_head = 1'b1;
                lock        = 1'b1;
                dir_d       = pend_q;
                state_d     = S_CHK;
            end
            S_CHK: begin
                check_inc = 1'b1;
                if (inc_length && length_q < MAX_L) length_d = length_q + 11'd1;
                state_d = S_HLD;
            end
            S_HLD: begin
                ld_head_into_prev = 1'b1;
                rst_address       = 1'b1;
                state_d           = S_SWAIT;
            end
            S_SWAIT: state_d = S_SLD;
            S_SLD: begin
                ld_q_into_curr = 1'b1;
                state_d        = S_SWR;
            end
            S_SWR: begin
                ld_prev_into_q    = 1'b1;
                ld_curr_into_prev = 1'b1;
                inc_address       = 1'b1;
                state_d           = last_seg ? S_DRST : S_SWAIT;
            end
            S_DEAD:  if (start) state_d = S_CLR;
            default: state_d = S_IDLE;
        endcase
    end

    // A wrap coinciding with the WAIT exit is kept so that tick is not lost.
    always_comb begin
        seg_d       = rst_address ? 11'd0 : (inc_address ? seg_q + 11'd1 : seg_q);
        sub_d       = (state_q == S_DRAW || state_q == S_FOOD) ? sub_q + 4'd1 : 4'd0;
        tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + TW'(1);
        tick_pend_d = tick_wrap | (tick_pend_q & ~(state_q == S_WAIT && state_d != S_WAIT));
    end

    assign draw_curr  = 1'b0;
    assign cnt_status = (state_q == S_DRAW || state_q == S_FOOD) ? sub_q : 4'd0;
    assign dir        = dir_q;
    assign length     = length_q;
    assign dead       = (state_q == S_DEAD);
endmodule

// File: tb/tb_snake_control.sv
// tb/tb_snake_control.sv - randomized move sequences checked against a transaction-level snake model
module tb_snake_control;
    localparam int INIT_LEN    = 4;
    localparam int MAX_LEN     = 5;
    localparam int MOVE_CYCLES = 110;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, isDead = 1'b0, inc_length = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head;
    logic        ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
    logic        draw_curr, food_en, lock, check_inc, dead;
    logic [3:0]  cnt_status;
    logic [2:0]  dir;
    logic [10:0] length;
    logic [13:0] strobes;

    snake_control #(.INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .MOVE_CYCLES(MOVE_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .isDead(isDead), .inc_length(inc_length),
        .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address), .rst_address(rst_address),
        .draw_q(draw_q), .update_head(update_head), .ld_head_into_prev(ld_head_into_prev),
        .ld_q_into_curr(ld_q_into_curr), .ld_prev_into_q(ld_prev_into_q),
        .ld_curr_into_prev(ld_curr_into_prev), .draw_curr(draw_curr), .food_en(food_en),
        .lock(lock), .check_inc(check_inc), .cnt_status(cnt_status), .dir(dir),
        .length(length), .dead(dead)
    );

    assign strobes = {ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
                      ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
                      draw_curr, food_en, lock, check_inc};

    always #5 clk = ~clk;

    // Edges since reset release; move ticks land on edges k*MOVE_CYCLES.
    int ecount;
    always @(posedge clk or negedge rst) begin
        if (!rst) ecount <= 0;
        else      ecount <= ecount + 1;
    end

    int vectors = 0;
    int errors  = 0;

    logic [2:0] dir_m, pend_m;
    int         len_m, u_prev, w_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] key2dir(input logic [3:0] k);
        if (k == 4'b0001) return 3'b100;
        if (k == 4'b0010) return 3'b110;
        if (k == 4'b0100) return 3'b000;
        return 3'b001;
    endfunction

    function automatic bit is_onehot(input logic [3:0] k);
        return (k == 4'b0001) || (k == 4'b0010) || (k == 4'b0100) || (k == 4'b1000);
    endfunction

    // Same axis (vertical/horizontal) but different heading means a reversal.
    function automatic bit reversal(input logic [2:0] a, input logic [2:0] b);
        return (a[2] == b[2]) && (a != b);
    endfunction

    function automatic int first_tick(input int u);
        int k;
        k = (u + MOVE_CYCLES - 1) / MOVE_CYCLES;
        if (k < 1) k = 1;
        return k * MOVE_CYCLES;
    endfunction

    task automatic init_check(input string tag);
        int n, first_draw, heads, defs, draws, bursts, foods, bad;
        bit prev_draw, seen_food, done;
        n = 0; first_draw = 0; heads = 0; defs = 0; draws = 0; bursts = 0; foods = 0; bad = 0;
        prev_draw = 0; seen_food = 0; done = 0;
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_clr_rst_address"}, rst_address, 1);
                start = 1'b0;
            end
            if (n == 2) begin
                chk({tag, "_length_after_clr"}, length, INIT_LEN);
                chk({tag, "_dir_after_clr"}, dir, 3'b100);
            end
            if (draw_q) begin
                if (cnt_status !== 4'(draws % 16)) bad++;
                if (first_draw == 0) first_draw = n;
                if (!prev_draw) bursts++;
                draws++;
            end else if (food_en) begin
                if (cnt_status !== 4'(foods % 16)) bad++;
                foods++;
                seen_food = 1;
            end else if (cnt_status !== 4'd0) bad++;
            prev_draw = draw_q;
            heads += int'(ld_head);
            defs  += int'(ld_q_def);
            if (seen_food && !food_en) begin
                done = 1;
                break;
            end
        end
        chk({tag, "_completed"}, done, 1);
        chk({tag, "_ld_head_pulses"}, heads, 1);
        chk({tag, "_ld_q_def_cycles"}, defs, INIT_LEN);
        chk({tag, "_first_draw_latency"}, first_draw, INIT_LEN + 4);
        chk({tag, "_draw_cycles"}, draws, 16 * INIT_LEN);
        chk({tag, "_draw_bursts"}, bursts, INIT_LEN);
        chk({tag, "_food_cycles"}, foods, 16);
        chk({tag, "_cnt_status_seq"}, bad, 0);
        chk({tag, "_length"}, length, INIT_LEN);
        w_edge = ecount;
        dir_m  = 3'b100;
        pend_m = 3'b100;
        len_m  = INIT_LEN;
    endtask

    task automatic do_move(input string tag, input logic [3:0] k, input bit inc, input bit die);
        int n, exp_upd, t, ldq, pairs, draws, foods, cis, bad;
        bit seen, seen_food, done, drawn;
        key = k;
        if (is_onehot(k) && !reversal(key2dir(k), dir_m)) pend_m = key2dir(k);
        inc_length = inc;
        isDead = 1'($urandom_range(0, 1));
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (update_head) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_upd_seen"}, seen, 1);
        if (!seen) return;
        t = first_tick(u_prev);
        exp_upd = ((w_edge > t) ? w_edge : t) + 1;
        chk({tag, "_upd_edge"}, ecount, exp_upd);
        chk({tag, "_lock"}, lock, 1);
        u_prev = ecount;
        dir_m = pend_m;
        if (inc && len_m < MAX_LEN) len_m++;
        key = 4'd0;
        n = 1; ldq = 0; pairs = 0; draws = 0; foods = 0; cis = 0; bad = 0;
        seen_food = 0; done = 0; drawn = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (n == 2) chk({tag, "_dir"}, dir, dir_m);
            if (n == 3) inc_length = 1'($urandom_range(0, 1));
            cis += int'(check_inc);
            ldq += int'(ld_q_into_curr);
            if (ld_prev_into_q && ld_curr_into_prev && inc_address) pairs++;
            if (draw_q) begin
                if (!drawn) begin
                    isDead = die;
                    drawn = 1;
                end
                if (cnt_status !== 4'(draws % 16)) bad++;
                draws++;
            end else if (food_en) begin
                if (cnt_status !== 4'(foods % 16)) bad++;
                foods++;
                seen_food = 1;
            end else if (cnt_status !== 4'd0) bad++;
            if (seen_food && !food_en) begin
                done = 1;
                break;
            end
        end
        chk({tag, "_completed"}, done, 1);
        chk({tag, "_total_cycles"}, n - 1, 20 + 20 * len_m);
        chk({tag, "_check_inc"}, cis, 1);
        chk({tag, "_shift_loads"}, ldq, len_m);
        chk({tag, "_shift_writes"}, pairs, len_m);
        chk({tag, "_draw_cycles"}, draws, 16 * len_m);
        chk({tag, "_food_cycles"}, foods, 16);
        chk({tag, "_cnt_status_seq"}, bad, 0);
        chk({tag, "_length"}, length, len_m);
        chk({tag, "_dead"}, dead, die);
        w_edge = ecount;
        isDead = 1'b0;
        inc_length = 1'b0;
    endtask

    function automatic logic [3:0] rand_key();
        if ($urandom_range(0, 1) == 0) return 4'b0001 << $urandom_range(0, 3);
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        int cnt;
        bit seen;
        repeat (3) @(negedge clk);
        chk("reset_strobes", strobes, 0);
        chk("reset_cnt_status", cnt_status, 0);
        chk("reset_dir", dir, 3'b100);
        chk("reset_length", length, INIT_LEN);
        chk("reset_dead", dead, 0);
        rst = 1'b1;
        u_prev = 0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (strobes != 0 || dead) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        init_check("start");
        do_move("mv_down_rejected", 4'b0010, 1'b0, 1'b0);
        do_move("mv_right", 4'b1000, 1'b0, 1'b0);
        do_move("mv_grow", 4'b0011, 1'b1, 1'b0);
        do_move("mv_max_len", 4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_move($sformatf("mv_rand%0d", i), rand_key(), ($urandom_range(0, 2) == 0), 1'b0);
        end
        do_move("mv_die", rand_key(), 1'b0, 1'b1);
        cnt = 0;
        repeat (250) begin
            @(negedge clk);
            cnt += int'(update_head);
        end
        chk("dead_no_upd", cnt, 0);
        chk("dead_held", dead, 1);

        init_check("restart");
        for (int i = 0; i < 3; i++) begin
            do_move($sformatf("mv_post%0d", i), rand_key(), ($urandom_range(0, 1) == 0), 1'b0);
        end

        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ld_prev_into_q) begin
                seen = 1;
                break;
            end
        end
        chk("swr_reached", seen, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_strobes", strobes, 0);
        chk("midrst_cnt_status", cnt_status, 0);
        chk("midrst_length", length, INIT_LEN);
        chk("midrst_dir", dir, 3'b100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        u_prev = 0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (strobes != 0 || dead) cnt++;
        end
        chk("post_rst_idle", cnt, 0);
        init_check("start2");
        do_move("mv_final", rand_key(), 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
